// File: rtl/sram_responder.sv
// ----------------------------------------------------------------------------
// sram_responder
//
// Purpose:
//   Behavioural SRAM target that sits on an asynchronous-SRAM style pin
//   interface but operates entirely on the rising edge of Clk.
//   - Writes are stored on every edge that sees a write request.
//   - Reads return data a fixed READ_LAT edges after the request is seen.
//   The shared Data bus is driven only from registers, so there is no
//   combinational path from any input to Data.
//
// Parameters:
//   DEPTH_LOG2 - the array holds 2**DEPTH_LOG2 words of 16 bits (must be < 20)
//   READ_LAT   - read latency in Clk cycles, 1..7
//
// Configuration macro:
//   SRAM_BYTE_LANE_EN - when defined, UB/LB select the bytes that a write
//                       stores. When undefined, every write stores the full
//                       word and UB/LB are ignored.
//
// Ports:
//   Clk    in   system clock, rising edge active
//   Reset  in   synchronous reset, active low
//   CE     in   chip enable, active low
//   OE     in   output enable, active low
//   WE     in   write enable, active low
//   UB     in   upper-byte enable, active low
//   LB     in   lower-byte enable, active low
//   ADDR   in   20-bit word address
//   Data   io   16-bit shared data bus; driven only while a read is presented
//   Err    out  one-cycle pulse when an out-of-range access is sampled
// ----------------------------------------------------------------------------
module sram_responder #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter int unsigned READ_LAT   = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CE,
    input  logic        OE,
    input  logic        WE,
    input  logic        UB,
    input  logic        LB,
    input  logic [19:0] ADDR,
    inout  wire  [15:0] Data,
    output logic        Err
);

    localparam int unsigned WORDS    = 1 << DEPTH_LOG2;
    localparam logic [2:0]  LAT_LOAD = 3'(READ_LAT - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RD_WAIT  = 2'd1,
        RD_DRIVE = 2'd2,
        WRITE    = 2'd3
    } state_e;

    state_e      state_q,  state_d;
    logic [2:0]  cnt_q,    cnt_d;
    logic [19:0] addr_q,   addr_d;
    logic        drive_q,  drive_d;
    logic [15:0] rdata_q,  rdata_d;
    logic        err_q,    err_d;

    logic [15:0] mem [WORDS];

    logic        write_req;
    logic        read_req;
    logic        addr_in_range;
    logic        latched_in_range;
    logic        mem_we;
    logic [1:0]  mem_be;

    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] rd_idx;

    assign write_req        = ~CE & ~WE;
    assign read_req         = ~CE & ~OE & WE;
    assign addr_in_range    = (ADDR   >> DEPTH_LOG2) == 20'd0;
    assign latched_in_range = (addr_q >> DEPTH_LOG2) == 20'd0;
    assign wr_idx           = ADDR[DEPTH_LOG2-1:0];
    assign rd_idx           = addr_q[DEPTH_LOG2-1:0];

`ifdef SRAM_BYTE_LANE_EN
    assign mem_be = {~UB, ~LB};
`else
    logic unused_lanes;
    assign unused_lanes = UB ^ LB;
    assign mem_be       = 2'b11;
`endif

    // Next-state and output logic.
    // NOTE: every variable gets a default before the case so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        drive_d = drive_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        mem_we  = 1'b0;

        if (write_req) begin
            // A write wins from any state; the bus is released on this edge
            // so the initiator can own Data from now on.
            state_d = WRITE;
            drive_d = 1'b0;
            cnt_d   = 3'd0;
            err_d   = ~addr_in_range;
            mem_we  = addr_in_range;
        end else begin
            unique case (state_q)
                IDLE, WRITE: begin
                    if (read_req) begin
                        state_d = RD_WAIT;
                        addr_d  = ADDR;
                        cnt_d   = LAT_LOAD;
                        drive_d = 1'b0;
                        err_d   = ~addr_in_range;
                    end else begin
                        state_d = IDLE;
                    end
                end

                RD_WAIT, RD_DRIVE: begin
                    if (CE || OE) begin
                        state_d = IDLE;
                        drive_d = 1'b0;
                    end else if (ADDR != addr_q) begin
                        // New address: treat as a fresh request and pay the
                        // whole latency again.
                        state_d = RD_WAIT;
                        addr_d  = ADDR;
                        cnt_d   = LAT_LOAD;
                        drive_d = 1'b0;
                        err_d   = ~addr_in_range;
                    end else if (state_q == RD_WAIT) begin
                        if (cnt_q == 3'd0) begin
                            state_d = RD_DRIVE;
                            drive_d = 1'b1;
                            rdata_d = latched_in_range ? mem[rd_idx] : 16'h0000;
                        end else begin
                            cnt_d = cnt_q - 3'd1;
                        end
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from pre-edge values, independent of statement order.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            addr_q  <= 20'd0;
            drive_q <= 1'b0;
            rdata_q <= 16'h0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            drive_q <= drive_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // NOTE: the array deliberately has no reset; contents survive Reset, and
    // a reset branch would also prevent mapping onto RAM macros. Reset only
    // gates the write enable so a write beat on the reset edge is dropped.
    always_ff @(posedge Clk) begin
        if (Reset && mem_we) begin
            if (mem_be[1]) mem[wr_idx][15:8] <= Data[15:8];
            if (mem_be[0]) mem[wr_idx][7:0]  <= Data[7:0];
        end
    end

    assign Data = drive_q ? rdata_q : 16'hzzzz;
    assign Err  = err_q;

endmodule

// File: tb/tb_sram_responder.sv
// ----------------------------------------------------------------------------
// tb_sram_responder
//
// Directed self-checking bench for sram_responder with default parameters
// (DEPTH_LOG2 = 8, READ_LAT = 2). The bus net is a pulled-up tri1, so a
// released bus reads as 16'hFFFF; no test data uses that value.
// ----------------------------------------------------------------------------
module tb_sram_responder;

    localparam int unsigned DEPTH_LOG2 = 8;
    localparam int unsigned READ_LAT   = 2;
    localparam logic [15:0] BUS_Z      = 16'hFFFF;

    logic        Clk;
    logic        Reset;
    logic        CE, OE, WE, UB, LB;
    logic [19:0] ADDR;
    logic        Err;

    tri1  [15:0] data_bus;
    logic        tb_drv;
    logic [15:0] tb_wdata;

    assign data_bus = tb_drv ? tb_wdata : 16'hzzzz;

    int checks = 0;
    int errors = 0;

    logic [15:0] word10;

    sram_responder #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .READ_LAT   (READ_LAT)
    ) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .CE    (CE),
        .OE    (OE),
        .WE    (WE),
        .UB    (UB),
        .LB    (LB),
        .ADDR  (ADDR),
        .Data  (data_bus),
        .Err   (Err)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic bus_idle();
        CE = 1'b1; OE = 1'b1; WE = 1'b1; UB = 1'b0; LB = 1'b0;
        ADDR = 20'd0; tb_drv = 1'b0; tb_wdata = 16'h0000;
    endtask

    task automatic write_word(input logic [19:0] a, input logic [15:0] d,
                              input logic ub, input logic lb);
        CE = 1'b0; OE = 1'b1; WE = 1'b0; UB = ub; LB = lb;
        ADDR = a; tb_wdata = d; tb_drv = 1'b1;
        tick();
        bus_idle();
        tick();
    endtask

    // Issues a read, reports whether the bus stayed released before the
    // latency elapsed, and returns the bus value READ_LAT edges later.
    task automatic read_back(input logic [19:0] a, output logic [15:0] val,
                             output logic early_z);
        early_z = 1'b1;
        CE = 1'b0; OE = 1'b0; WE = 1'b1; ADDR = a; tb_drv = 1'b0;
        tick();
        if (data_bus !== BUS_Z) early_z = 1'b0;
        for (int i = 1; i < READ_LAT; i++) begin
            tick();
            if (data_bus !== BUS_Z) early_z = 1'b0;
        end
        tick();
        val = data_bus;
        bus_idle();
        tick();
    endtask

    task automatic test_reset();
        bus_idle();
        Reset = 1'b0;
        tick();
        checks++;
        if (data_bus !== BUS_Z) begin
            errors++; $display("FAIL reset_data: got %h want %h", data_bus, BUS_Z);
        end
        checks++;
        if (Err !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b want 0", Err);
        end
        Reset = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        logic [15:0] v;
        logic        z;
        write_word(20'h00010, 16'hBEEF, 1'b0, 1'b0);
        read_back(20'h00010, v, z);
        checks++;
        if (z !== 1'b1) begin
            errors++; $display("FAIL wr_rd_early_z: bus driven before latency, want released");
        end
        checks++;
        if (v !== 16'hBEEF) begin
            errors++; $display("FAIL wr_rd_data: got %h want BEEF", v);
        end
    endtask

    task automatic test_byte_lane();
        logic [15:0] v;
        logic        z;
        logic [15:0] exp_a, exp_b;
`ifdef SRAM_BYTE_LANE_EN
        exp_a = 16'h12EF;
        exp_b = 16'h12CD;
`else
        exp_a = 16'h1234;
        exp_b = 16'h56CD;
`endif
        write_word(20'h00010, 16'h1234, 1'b0, 1'b1);
        read_back(20'h00010, v, z);
        checks++;
        if (v !== exp_a) begin
            errors++; $display("FAIL lane_upper: got %h want %h", v, exp_a);
        end
        write_word(20'h00010, 16'h56CD, 1'b1, 1'b0);
        read_back(20'h00010, v, z);
        checks++;
        if (v !== exp_b) begin
            errors++; $display("FAIL lane_lower: got %h want %h", v, exp_b);
        end
        word10 = exp_b;
    endtask

    task automatic test_out_of_range();
        logic [15:0] v;
        logic        z;
        CE = 1'b0; OE = 1'b0; WE = 1'b1; ADDR = 20'h00100;
        tick();
        checks++;
        if (Err !== 1'b1) begin
            errors++; $display("FAIL oor_rd_err_on: got %b want 1", Err);
        end
        tick();
        checks++;
        if (Err !== 1'b0) begin
            errors++; $display("FAIL oor_rd_err_off: got %b want 0", Err);
        end
        checks++;
        if (data_bus !== BUS_Z) begin
            errors++; $display("FAIL oor_rd_wait_z: got %h want %h", data_bus, BUS_Z);
        end
        tick();
        checks++;
        if (data_bus !== 16'h0000) begin
            errors++; $display("FAIL oor_rd_data: got %h want 0000", data_bus);
        end
        bus_idle();
        tick();
        // Out-of-range write whose low bits alias word 0x10.
        CE = 1'b0; OE = 1'b1; WE = 1'b0; ADDR = 20'h00110;
        tb_wdata = 16'hDEAD; tb_drv = 1'b1;
        tick();
        checks++;
        if (Err !== 1'b1) begin
            errors++; $display("FAIL oor_wr_err_on: got %b want 1", Err);
        end
        bus_idle();
        tick();
        checks++;
        if (Err !== 1'b0) begin
            errors++; $display("FAIL oor_wr_err_off: got %b want 0", Err);
        end
        read_back(20'h00010, v, z);
        checks++;
        if (v !== word10) begin
            errors++; $display("FAIL oor_wr_no_store: got %h want %h", v, word10);
        end
    endtask

    task automatic test_addr_change();
        write_word(20'h00001, 16'h1111, 1'b0, 1'b0);
        write_word(20'h00002, 16'h2222, 1'b0, 1'b0);
        CE = 1'b0; OE = 1'b0; WE = 1'b1; ADDR = 20'h00001;
        tick();
        ADDR = 20'h00002;
        tick();
        checks++;
        if (data_bus !== BUS_Z) begin
            errors++; $display("FAIL chg_edge0_z: got %h want %h", data_bus, BUS_Z);
        end
        tick();
        checks++;
        if (data_bus !== BUS_Z) begin
            errors++; $display("FAIL chg_edge1_z: got %h want %h", data_bus, BUS_Z);
        end
        tick();
        checks++;
        if (data_bus !== 16'h2222) begin
            errors++; $display("FAIL chg_data: got %h want 2222", data_bus);
        end
    endtask

    // Continues from test_addr_change with word 2 on the bus.
    task automatic test_back_to_back();
        ADDR = 20'h00001;
        tick();
        checks++;
        if (data_bus !== BUS_Z) begin
            errors++; $display("FAIL b2b_release: got %h want %h", data_bus, BUS_Z);
        end
        tick();
        checks++;
        if (data_bus !== BUS_Z) begin
            errors++; $display("FAIL b2b_wait_z: got %h want %h", data_bus, BUS_Z);
        end
        tick();
        checks++;
        if (data_bus !== 16'h1111) begin
            errors++; $display("FAIL b2b_data: got %h want 1111", data_bus);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_abort();
        CE = 1'b0; OE = 1'b0; WE = 1'b1; ADDR = 20'h00002;
        tick();
        CE = 1'b1;
        tick();
        tick();
        checks++;
        if (data_bus !== BUS_Z) begin
            errors++; $display("FAIL abort_ce_z: got %h want %h", data_bus, BUS_Z);
        end
        CE = 1'b0; ADDR = 20'h00001;
        tick();
        tick();
        tick();
        checks++;
        if (data_bus !== 16'h1111) begin
            errors++; $display("FAIL abort_pre_data: got %h want 1111", data_bus);
        end
        OE = 1'b1;
        tick();
        checks++;
        if (data_bus !== BUS_Z) begin
            errors++; $display("FAIL abort_oe_z: got %h want %h", data_bus, BUS_Z);
        end
        bus_idle();
        tick();
    endtask

    task automatic test_we_during_drive();
        logic [15:0] v;
        logic        z;
        write_word(20'h00020, 16'h0F0F, 1'b0, 1'b0);
        CE = 1'b0; OE = 1'b0; WE = 1'b1; ADDR = 20'h00020;
        tick();
        tick();
        tick();
        checks++;
        if (data_bus !== 16'h0F0F) begin
            errors++; $display("FAIL we_pre_data: got %h want 0F0F", data_bus);
        end
        WE = 1'b0;
        tick();
        checks++;
        if (data_bus !== BUS_Z) begin
            errors++; $display("FAIL we_release: got %h want %h", data_bus, BUS_Z);
        end
        tb_wdata = 16'hA5A5; tb_drv = 1'b1;
        tick();
        bus_idle();
        tick();
        read_back(20'h00020, v, z);
        checks++;
        if (v !== 16'hA5A5) begin
            errors++; $display("FAIL we_stored: got %h want A5A5", v);
        end
    endtask

    task automatic test_reset_mid_access();
        logic [15:0] v;
        logic        z;
        write_word(20'h00003, 16'h5A5A, 1'b0, 1'b0);
        CE = 1'b0; OE = 1'b0; WE = 1'b1; ADDR = 20'h00003;
        tick();
        tick();
        tick();
        Reset = 1'b0;
        tick();
        checks++;
        if (data_bus !== BUS_Z) begin
            errors++; $display("FAIL rst_rd_release: got %h want %h", data_bus, BUS_Z);
        end
        Reset = 1'b1;
        tick();
        checks++;
        if (data_bus !== BUS_Z) begin
            errors++; $display("FAIL rst_rd_restart_z: got %h want %h", data_bus, BUS_Z);
        end
        tick();
        tick();
        checks++;
        if (data_bus !== 16'h5A5A) begin
            errors++; $display("FAIL rst_rd_data: got %h want 5A5A", data_bus);
        end
        bus_idle();
        tick();
        // Write beat presented on a reset edge must not reach the array.
        CE = 1'b0; OE = 1'b1; WE = 1'b0; ADDR = 20'h00003;
        tb_wdata = 16'h0000; tb_drv = 1'b1;
        Reset = 1'b0;
        tick();
        Reset = 1'b1;
        bus_idle();
        tick();
        read_back(20'h00003, v, z);
        checks++;
        if (v !== 16'h5A5A) begin
            errors++; $display("FAIL rst_wr_blocked: got %h want 5A5A", v);
        end
    endtask

    initial begin
        bus_idle();
        Reset  = 1'b1;
        word10 = 16'h0000;
        test_reset();
        test_write_read();
        test_byte_lane();
        test_out_of_range();
        test_addr_change();
        test_back_to_back();
        test_abort();
        test_we_during_drive();
        test_reset_mid_access();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
